// File: rtl/mandel_scan_pkg.sv
// Shared definitions for the Mandelbrot scan driver: widths, iterator saturation
// value and FSM state encoding.
package mandel_scan_pkg;

    localparam int COORD_W = 14;
    localparam int RES_W   = 8;
    localparam int ITER_W  = 7;
    localparam int IDX_W   = 8;

    localparam logic [ITER_W-1:0] MAX_ITER_SAT = 7'h7F;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD_X = 3'd1;
    localparam logic [2:0] ST_LOAD_Y = 3'd2;
    localparam logic [2:0] ST_RUN    = 3'd3;
    localparam logic [2:0] ST_EMIT   = 3'd4;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [IDX_W-1:0]   idx_t;

    // A pixel is finished once the iterator flags escape or hits its saturation count.
    function automatic logic pixel_finished(input logic [RES_W-1:0] res,
                                            input logic [ITER_W-1:0] max_iter);
        return res[RES_W-1] || (res[ITER_W-1:0] == max_iter);
    endfunction

endpackage

// File: rtl/mandel_coord_stepper.sv
// Holds the current pixel position and coordinates of a scan and steps them
// in raster order; coordinate sums wrap modulo 2^14.
module mandel_coord_stepper
    import mandel_scan_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               load,
    input  logic               advance,
    input  logic [COORD_W-1:0] x_start,
    input  logic [COORD_W-1:0] y_start,
    input  logic [COORD_W-1:0] step,
    input  logic [IDX_W-1:0]   cols_m1,
    input  logic [IDX_W-1:0]   rows_m1,
    output logic [IDX_W-1:0]   col,
    output logic [IDX_W-1:0]   row,
    output logic [COORD_W-1:0] cur_x,
    output logic [COORD_W-1:0] cur_y,
    output logic [COORD_W-1:0] adv_x,
    output logic               last_pix
);

    coord_t x0;
    coord_t stp;
    idx_t   cols_lim;
    idx_t   rows_lim;
    logic   last_col;

    assign last_col = (col == cols_lim);
    assign last_pix = last_col && (row == rows_lim);

    // adv_x is exposed so the driver can register the next x load in the same edge as the advance.
    always_comb begin
        adv_x = cur_x + stp;
        if (last_col) begin
            adv_x = x0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            x0       <= '0;
            stp      <= '0;
            cols_lim <= '0;
            rows_lim <= '0;
            col      <= '0;
            row      <= '0;
            cur_x    <= '0;
            cur_y    <= '0;
        end else if (load) begin
            x0       <= x_start;
            stp      <= step;
            cols_lim <= cols_m1;
            rows_lim <= rows_m1;
            col      <= '0;
            row      <= '0;
            cur_x    <= x_start;
            cur_y    <= y_start;
        end else if (advance) begin
            cur_x <= adv_x;
            if (last_col) begin
                col   <= '0;
                row   <= row + 8'd1;
                cur_y <= cur_y + stp;
            end else begin
                col <= col + 8'd1;
            end
        end
    end

endmodule

// File: rtl/mandel_scan_driver.sv
// Scans a rectangular grid of points through a Mandelbrot iterator, loading x then y
// per pixel and streaming {escape, iter} results with their column/row.
module mandel_scan_driver
    import mandel_scan_pkg::*;
#(
    parameter logic [ITER_W-1:0] MAX_ITER = MAX_ITER_SAT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [COORD_W-1:0] x_start,
    input  logic [COORD_W-1:0] y_start,
    input  logic [COORD_W-1:0] step,
    input  logic [IDX_W-1:0]   cols_m1,
    input  logic [IDX_W-1:0]   rows_m1,
    output logic [COORD_W-1:0] value_out,
    output logic               input_x,
    output logic               in_enable,
    input  logic [RES_W-1:0]   result_in,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [RES_W-1:0]   pix_data,
    output logic [IDX_W-1:0]   pix_col,
    output logic [IDX_W-1:0]   pix_row,
    output logic               busy,
    output logic               done
);

    logic [2:0] state;
    logic       accept;
    logic       transfer;
    idx_t       col;
    idx_t       row;
    coord_t     cur_x;
    coord_t     cur_y;
    coord_t     adv_x;
    logic       last_pix;

    assign accept   = (state == ST_IDLE) && start;
    assign transfer = (state == ST_EMIT) && pix_valid && pix_ready;

    mandel_coord_stepper u_stepper (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (abort),
        .load     (accept),
        .advance  (transfer),
        .x_start  (x_start),
        .y_start  (y_start),
        .step     (step),
        .cols_m1  (cols_m1),
        .rows_m1  (rows_m1),
        .col      (col),
        .row      (row),
        .cur_x    (cur_x),
        .cur_y    (cur_y),
        .adv_x    (adv_x),
        .last_pix (last_pix)
    );

    // Outputs are registered, so each transition drives the values of the state being entered.
    always_ff @(posedge clk) begin
        if (!rst_n || abort) begin
            state     <= ST_IDLE;
            value_out <= '0;
            input_x   <= 1'b0;
            in_enable <= 1'b0;
            pix_valid <= 1'b0;
            pix_data  <= '0;
            pix_col   <= '0;
            pix_row   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_LOAD_X;
                        busy      <= 1'b1;
                        in_enable <= 1'b1;
                        input_x   <= 1'b1;
                        value_out <= x_start;
                    end
                end
                ST_LOAD_X: begin
                    state     <= ST_LOAD_Y;
                    input_x   <= 1'b0;
                    value_out <= cur_y;
                end
                ST_LOAD_Y: begin
                    state     <= ST_RUN;
                    in_enable <= 1'b0;
                end
                ST_RUN: begin
                    if (pixel_finished(result_in, MAX_ITER)) begin
                        state     <= ST_EMIT;
                        pix_valid <= 1'b1;
                        pix_data  <= result_in;
                        pix_col   <= col;
                        pix_row   <= row;
                    end
                end
                ST_EMIT: begin
                    if (pix_ready) begin
                        pix_valid <= 1'b0;
                        if (last_pix) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state     <= ST_LOAD_X;
                            in_enable <= 1'b1;
                            input_x   <= 1'b1;
                            value_out <= adv_x;
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    busy      <= 1'b0;
                    in_enable <= 1'b0;
                    pix_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mandel_scan_driver.sv
// Scoreboard bench for mandel_scan_driver with a behavioural iterator that escapes
// after a programmable count or saturates at 0x7F.
module tb_mandel_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [13:0] x_start;
    logic [13:0] y_start;
    logic [13:0] step;
    logic [7:0]  cols_m1;
    logic [7:0]  rows_m1;
    logic [13:0] value_out;
    logic        input_x;
    logic        in_enable;
    logic [7:0]  result_in;
    logic        pix_valid;
    logic        pix_ready;
    logic [7:0]  pix_data;
    logic [7:0]  pix_col;
    logic [7:0]  pix_row;
    logic        busy;
    logic        done;

    typedef struct packed {
        logic [7:0] data;
        logic [7:0] col;
        logic [7:0] row;
    } pix_t;

    pix_t        pix_q[$];
    logic [13:0] xq[$];
    logic [13:0] yq[$];
    pix_t        exp_pix;
    logic [13:0] exp_v;

    int          errors = 0;
    int          checks = 0;
    int          done_seen = 0;
    logic [6:0]  esc_after = 7'd3;
    logic [6:0]  it_cnt;
    logic        it_esc;

    always #5 clk = ~clk;

    mandel_scan_driver dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .x_start   (x_start),
        .y_start   (y_start),
        .step      (step),
        .cols_m1   (cols_m1),
        .rows_m1   (rows_m1),
        .value_out (value_out),
        .input_x   (input_x),
        .in_enable (in_enable),
        .result_in (result_in),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_data  (pix_data),
        .pix_col   (pix_col),
        .pix_row   (pix_row),
        .busy      (busy),
        .done      (done)
    );

    // Iterator model: a y load restarts the count; escape_after=0 means never escape.
    assign result_in = {it_esc, it_cnt};
    always @(posedge clk) begin
        if (!rst_n) begin
            it_cnt <= 7'd0;
            it_esc <= 1'b0;
        end else if (in_enable && !input_x) begin
            it_cnt <= 7'd0;
            it_esc <= 1'b0;
        end else if (!it_esc && it_cnt != 7'h7F) begin
            it_cnt <= it_cnt + 7'd1;
            if (esc_after != 7'd0 && (it_cnt + 7'd1) == esc_after) begin
                it_esc <= 1'b1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic reportFail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s", name);
    endtask

    // Monitor: pops the scoreboard on every pixel transfer and every coordinate load.
    always @(negedge clk) begin
        if (pix_valid === 1'b1 && pix_ready === 1'b1) begin
            if (pix_q.size() == 0) begin
                reportFail("pix_unexpected");
            end else begin
                exp_pix = pix_q.pop_front();
                checkOutput("pix_data", {24'd0, pix_data}, {24'd0, exp_pix.data});
                checkOutput("pix_col", {24'd0, pix_col}, {24'd0, exp_pix.col});
                checkOutput("pix_row", {24'd0, pix_row}, {24'd0, exp_pix.row});
            end
        end
        if (in_enable === 1'b1 && input_x === 1'b1) begin
            if (xq.size() == 0) begin
                reportFail("x_load_unexpected");
            end else begin
                exp_v = xq.pop_front();
                checkOutput("x_load", {18'd0, value_out}, {18'd0, exp_v});
            end
        end
        if (in_enable === 1'b1 && input_x === 1'b0) begin
            if (yq.size() == 0) begin
                reportFail("y_load_unexpected");
            end else begin
                exp_v = yq.pop_front();
                checkOutput("y_load", {18'd0, value_out}, {18'd0, exp_v});
            end
        end
        if (done === 1'b1) begin
            done_seen++;
        end
    end

    task automatic applyStimulus(input logic [13:0] x0, input logic [13:0] y0, input logic [13:0] st,
                                 input logic [7:0] cm1, input logic [7:0] rm1);
        x_start = x0;
        y_start = y0;
        step    = st;
        cols_m1 = cm1;
        rows_m1 = rm1;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
    endtask

    task automatic pushScan(input logic [13:0] x0, input logic [13:0] y0, input logic [13:0] st,
                            input int cm1, input int rm1, input logic [7:0] pdata);
        logic [13:0] xv;
        logic [13:0] yv;
        yv = y0;
        for (int r = 0; r <= rm1; r++) begin
            xv = x0;
            for (int c = 0; c <= cm1; c++) begin
                xq.push_back(xv);
                yq.push_back(yv);
                pix_q.push_back({pdata, 8'(c), 8'(r)});
                xv = xv + st;
            end
            yv = yv + st;
        end
    endtask

    task automatic waitDone(input string name, input int budget);
        int n;
        int d0;
        n  = 0;
        d0 = done_seen;
        while (done !== 1'b1 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (done !== 1'b1) begin
            reportFail({name, "_done_timeout"});
        end else begin
            checkOutput({name, "_busy_at_done"}, {31'd0, busy}, 32'd0);
            @(posedge clk);
            #1;
            checkOutput({name, "_done_width"}, {31'd0, done}, 32'd0);
            checkOutput({name, "_done_count"}, done_seen - d0, 32'd1);
        end
    endtask

    task automatic waitValid(input string name, input int budget);
        int n;
        n = 0;
        while (pix_valid !== 1'b1 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (pix_valid !== 1'b1) begin
            reportFail({name, "_valid_timeout"});
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_pix_valid"}, {31'd0, pix_valid}, 32'd0);
        checkOutput({tag, "_in_enable"}, {31'd0, in_enable}, 32'd0);
        checkOutput({tag, "_input_x"}, {31'd0, input_x}, 32'd0);
        checkOutput({tag, "_value_out"}, {18'd0, value_out}, 32'd0);
        checkOutput({tag, "_pix_data"}, {24'd0, pix_data}, 32'd0);
        checkOutput({tag, "_pix_col"}, {24'd0, pix_col}, 32'd0);
        checkOutput({tag, "_pix_row"}, {24'd0, pix_row}, 32'd0);
        checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
        checkOutput({tag, "_done"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] snap;
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        pix_ready = 1'b1;
        x_start   = '0;
        y_start   = '0;
        step      = '0;
        cols_m1   = '0;
        rows_m1   = '0;
        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] 2x2 scan, escape after 3");
        esc_after = 7'd3;
        pushScan(14'h3000, 14'h3000, 14'h0400, 1, 1, 8'h83);
        applyStimulus(14'h3000, 14'h3000, 14'h0400, 8'd1, 8'd1);
        checkOutput("busy_after_start", {31'd0, busy}, 32'd1);
        waitDone("scan2x2", 200);

        $display("[TB] single pixel, saturating iterator");
        esc_after = 7'd0;
        pushScan(14'h0123, 14'h0456, 14'h0001, 0, 0, 8'h7F);
        applyStimulus(14'h0123, 14'h0456, 14'h0001, 8'd0, 8'd0);
        waitDone("saturate", 400);

        $display("[TB] backpressure for 10 cycles");
        esc_after = 7'd3;
        pix_ready = 1'b0;
        pushScan(14'h0100, 14'h0200, 14'h0010, 1, 0, 8'h83);
        applyStimulus(14'h0100, 14'h0200, 14'h0010, 8'd1, 8'd0);
        waitValid("stall", 50);
        snap = {pix_valid, pix_data, pix_col, pix_row, in_enable, 6'd0};
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checkOutput("stall_hold", {pix_valid, pix_data, pix_col, pix_row, in_enable, 6'd0}, snap);
        end
        pix_ready = 1'b1;
        waitDone("stall", 100);

        $display("[TB] coordinate wrap cases");
        pushScan(14'h1F00, 14'h0000, 14'h0200, 1, 0, 8'h83);
        applyStimulus(14'h1F00, 14'h0000, 14'h0200, 8'd1, 8'd0);
        waitDone("wrap_a", 100);
        pushScan(14'h1FFF, 14'h0000, 14'h0001, 1, 0, 8'h83);
        applyStimulus(14'h1FFF, 14'h0000, 14'h0001, 8'd1, 8'd0);
        waitDone("wrap_b", 100);
        pushScan(14'h1FFF, 14'h3FFF, 14'h2001, 1, 1, 8'h83);
        applyStimulus(14'h1FFF, 14'h3FFF, 14'h2001, 8'd1, 8'd1);
        waitDone("wrap_c", 200);

        $display("[TB] abort during RUN");
        esc_after = 7'd0;
        xq.push_back(14'h0AAA);
        yq.push_back(14'h0BBB);
        applyStimulus(14'h0AAA, 14'h0BBB, 14'h0010, 8'd3, 8'd3);
        repeat (20) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        checkResetOutputs("abort");
        esc_after = 7'd3;
        pushScan(14'h0055, 14'h0066, 14'h0001, 0, 0, 8'h83);
        applyStimulus(14'h0055, 14'h0066, 14'h0001, 8'd0, 8'd0);
        waitDone("after_abort", 100);

        $display("[TB] reset during EMIT");
        pix_ready = 1'b0;
        xq.push_back(14'h0321);
        yq.push_back(14'h0654);
        applyStimulus(14'h0321, 14'h0654, 14'h0001, 8'd2, 8'd2);
        waitValid("rst_emit", 50);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        pix_ready = 1'b1;
        checkResetOutputs("rst_emit");
        pushScan(14'h0777, 14'h0888, 14'h0001, 0, 0, 8'h83);
        applyStimulus(14'h0777, 14'h0888, 14'h0001, 8'd0, 8'd0);
        waitDone("after_rst", 100);

        $display("[TB] start while busy is ignored");
        pushScan(14'h0800, 14'h0900, 14'h0040, 1, 1, 8'h83);
        applyStimulus(14'h0800, 14'h0900, 14'h0040, 8'd1, 8'd1);
        repeat (3) @(posedge clk);
        #1;
        applyStimulus(14'h2222, 14'h3333, 14'h0100, 8'd5, 8'd5);
        repeat (9) @(posedge clk);
        #1;
        applyStimulus(14'h2222, 14'h3333, 14'h0100, 8'd5, 8'd5);
        waitDone("busy_start", 200);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("pix_q_left", pix_q.size(), 32'd0);
        checkOutput("xq_left", xq.size(), 32'd0);
        checkOutput("yq_left", yq.size(), 32'd0);
        checkOutput("idle_busy", {31'd0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
